// File: rtl/eth_tx_framer.sv
// eth_tx_framer
// Byte-wide Ethernet transmit framer. Takes payload bytes (DA through end of
// payload) on a valid/ready stream and produces the PHY byte stream:
// 7x 0x55 preamble, 0xD5 SFD, payload, optional zero pad, 4-byte FCS, then a
// forced idle gap. An input underrun inside a frame is signalled with one
// tx_er cycle, after which the rest of the input frame is discarded.
//
// Timing model: every PHY output is a register loaded from the state of the
// previous cycle, so tx_d always lags the FSM by one clock. A byte accepted in
// DATA during cycle N is therefore on tx_d in cycle N+1.
module eth_tx_framer #(
  parameter bit PAD_EN  = 1'b1,
  parameter int MIN_LEN = 60,
  parameter int IFG_LEN = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tx_en,
  output logic [7:0] tx_d,
  output logic       tx_er,
  output logic       busy
);

  // The first preamble byte is launched from the IDLE decision cycle, so the
  // PRE state only needs to launch the remaining six.
  localparam int PRE_CYCLES = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_FLUSH,
    S_IFG
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] phase_cnt_reg;
  logic [15:0] byte_cnt_reg;
  logic [15:0] byte_cnt_inc;
  logic [31:0] crc_reg;
  logic [31:0] crc_inv;
  logic        accept;
  logic        tx_en_reg;
  logic        tx_en_next;
  logic        tx_er_reg;
  logic        tx_er_next;
  logic [7:0]  tx_d_reg;
  logic [7:0]  tx_d_next;

  // Reflected CRC-32 (poly 0xEDB88320 in LSB-first form), one byte per call.
  // Keeping the register reflected means ~crc sent LSB byte first is already
  // the on-wire FCS order; no extra bit reversal is needed.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign in_ready     = (state_reg == S_DATA) || (state_reg == S_FLUSH);
  assign busy         = (state_reg != S_IDLE);
  assign accept       = in_valid && in_ready;
  assign crc_inv      = ~crc_reg;
  // Saturating length so oversize frames still finish normally.
  assign byte_cnt_inc = (byte_cnt_reg == 16'hFFFF) ? byte_cnt_reg
                                                   : byte_cnt_reg + 16'd1;

  assign tx_en = tx_en_reg;
  assign tx_er = tx_er_reg;
  assign tx_d  = tx_d_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) state_next = S_PRE;
      end
      S_PRE: begin
        if (phase_cnt_reg == 16'(PRE_CYCLES - 1)) state_next = S_SFD;
      end
      S_SFD: begin
        state_next = S_DATA;
      end
      S_DATA: begin
        if (!in_valid) begin
          state_next = S_FLUSH;
        end else if (in_last) begin
          state_next = (PAD_EN && (byte_cnt_inc < 16'(MIN_LEN))) ? S_PAD : S_FCS;
        end
      end
      S_PAD: begin
        if (byte_cnt_inc >= 16'(MIN_LEN)) state_next = S_FCS;
      end
      S_FCS: begin
        if (phase_cnt_reg == 16'd3) state_next = S_IFG;
      end
      S_FLUSH: begin
        if (in_valid && in_last) state_next = S_IFG;
      end
      S_IFG: begin
        // IFG_LEN+1 cycles: the first one still shows the last FCS byte on
        // tx_d, and the IDLE decision cycle adds one more idle cycle.
        if (phase_cnt_reg == 16'(IFG_LEN)) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: the byte to launch onto the PHY at the next clock edge.
  always_comb begin
    tx_en_next = 1'b0;
    tx_er_next = 1'b0;
    tx_d_next  = 8'h00;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          tx_en_next = 1'b1;
          tx_d_next  = 8'h55;
        end
      end
      S_PRE: begin
        tx_en_next = 1'b1;
        tx_d_next  = 8'h55;
      end
      S_SFD: begin
        tx_en_next = 1'b1;
        tx_d_next  = 8'hD5;
      end
      S_DATA: begin
        tx_en_next = 1'b1;
        if (in_valid) begin
          tx_d_next = in_data;
        end else begin
          tx_er_next = 1'b1;
        end
      end
      S_PAD: begin
        tx_en_next = 1'b1;
      end
      S_FCS: begin
        tx_en_next = 1'b1;
        tx_d_next  = crc_inv[{phase_cnt_reg[1:0], 3'b000} +: 8];
      end
      default: begin
        tx_en_next = 1'b0;
      end
    endcase
  end

  // PHY output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en_reg <= 1'b0;
      tx_er_reg <= 1'b0;
      tx_d_reg  <= 8'h00;
    end else begin
      tx_en_reg <= tx_en_next;
      tx_er_reg <= tx_er_next;
      tx_d_reg  <= tx_d_next;
    end
  end

  // Datapath: phase counter, running CRC and frame length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt_reg <= 16'd0;
      byte_cnt_reg  <= 16'd0;
      crc_reg       <= 32'hFFFFFFFF;
    end else begin
      phase_cnt_reg <= (state_next != state_reg) ? 16'd0 : phase_cnt_reg + 16'd1;
      case (state_reg)
        S_SFD: begin
          crc_reg      <= 32'hFFFFFFFF;
          byte_cnt_reg <= 16'd0;
        end
        S_DATA: begin
          if (accept) begin
            crc_reg      <= crc32_byte(crc_reg, in_data);
            byte_cnt_reg <= byte_cnt_inc;
          end
        end
        S_PAD: begin
          crc_reg      <= crc32_byte(crc_reg, 8'h00);
          byte_cnt_reg <= byte_cnt_inc;
        end
        default: begin
          crc_reg <= crc_reg;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed testbench for eth_tx_framer. dut0 runs without padding, dut1 with
// padding to 60 bytes. A monitor records {tx_en, tx_er, tx_d} of the selected
// instance every cycle; each scenario then inspects that timeline.
module tb_eth_tx_framer;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      iv;
  logic [1:0]      il;
  logic [1:0][7:0] id;
  logic [1:0]      ir;
  logic [1:0]      ten;
  logic [1:0]      ter;
  logic [1:0]      bsy;
  logic [1:0][7:0] td;

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  tl[$];
  bit          mon_on = 1'b0;
  int          mon_sel = 0;
  logic [7:0]  fb[$];
  int          seg_start[$];
  int          seg_len[$];
  int          n_en;
  int          n_er;
  logic [7:0]  exp1[21];

  always #5 clk = ~clk;

  eth_tx_framer #(.PAD_EN(1'b0), .MIN_LEN(60), .IFG_LEN(12)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_data(id[0]), .in_last(il[0]), .in_ready(ir[0]),
    .tx_en(ten[0]), .tx_d(td[0]), .tx_er(ter[0]), .busy(bsy[0])
  );

  eth_tx_framer #(.PAD_EN(1'b1), .MIN_LEN(60), .IFG_LEN(12)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_data(id[1]), .in_last(il[1]), .in_ready(ir[1]),
    .tx_en(ten[1]), .tx_d(td[1]), .tx_er(ter[1]), .busy(bsy[1])
  );

  // Record the PHY side of the observed instance, away from the active edge.
  always @(negedge clk) begin
    if (mon_on) tl.push_back({ten[mon_sel], ter[mon_sel], td[mon_sel]});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_mon(input int u);
    mon_sel = u;
    tl.delete();
    mon_on = 1'b1;
  endtask

  // Present n bytes base, base+1, ...; optionally flag the last one.
  task automatic send_bytes(input int u, input int n, input int base, input bit last);
    int tmo_cnt;
    tmo_cnt = 0;
    for (int k = 0; k < n; k++) begin
      bit ok;
      int t;
      iv[u] = 1'b1;
      id[u] = 8'(base + k);
      il[u] = last && (k == n - 1);
      ok = 1'b0;
      t = 0;
      while (!ok && t < 300) begin
        @(negedge clk);
        ok = ir[u];
        @(posedge clk);
        #1;
        t++;
      end
      if (!ok) tmo_cnt++;
    end
    check("accept_timeouts", 32'(tmo_cnt), 32'd0);
  endtask

  task automatic wait_idle(input int u);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bsy[u] && t < 500);
    check("busy_returns_low", 32'(bsy[u]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b0;
  endtask

  // Split the timeline into tx_en segments and collect transmitted bytes.
  task automatic analyze();
    logic prev;
    prev = 1'b0;
    n_en = 0;
    n_er = 0;
    fb.delete();
    seg_start.delete();
    seg_len.delete();
    for (int i = 0; i < tl.size(); i++) begin
      if (tl[i][9]) begin
        n_en++;
        fb.push_back(tl[i][7:0]);
        if (!prev) begin
          seg_start.push_back(i);
          seg_len.push_back(0);
        end
        seg_len[seg_len.size() - 1] = seg_len[seg_len.size() - 1] + 1;
      end
      if (tl[i][8]) n_er++;
      prev = tl[i][9];
    end
  endtask

  // Receive-side checker: CRC over every byte after the SFD of a segment,
  // returned in MSB-first form so a good frame yields 0xC704DD7B.
  function automatic logic [31:0] residue(input int s, input int l);
    logic [31:0] c;
    logic [31:0] r;
    c = 32'hFFFFFFFF;
    for (int i = s + 8; i < s + l; i++) begin
      c = c ^ {24'h000000, tl[i][7:0]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    for (int b = 0; b < 32; b++) r[b] = c[31 - b];
    return r;
  endfunction

  initial begin
    int nz;
    int er_idx;

    iv = '0;
    il = '0;
    id = '0;
    for (int k = 0; k < 7; k++) exp1[k] = 8'h55;
    exp1[7] = 8'hD5;
    for (int k = 0; k < 9; k++) exp1[8 + k] = 8'(8'h31 + k);
    exp1[17] = 8'h26;
    exp1[18] = 8'h39;
    exp1[19] = 8'hF4;
    exp1[20] = 8'hCB;

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst_tx_en%0d", u), 32'(ten[u]), 32'd0);
      check($sformatf("rst_tx_er%0d", u), 32'(ter[u]), 32'd0);
      check($sformatf("rst_tx_d%0d", u), 32'(td[u]), 32'd0);
      check($sformatf("rst_in_ready%0d", u), 32'(ir[u]), 32'd0);
      check($sformatf("rst_busy%0d", u), 32'(bsy[u]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: "123456789" without padding.
    start_mon(0);
    send_bytes(0, 9, 8'h31, 1'b1);
    iv[0] = 1'b0;
    il[0] = 1'b0;
    wait_idle(0);
    analyze();
    check("s1_segments", 32'(seg_start.size()), 32'd1);
    check("s1_en_cycles", 32'(n_en), 32'd21);
    check("s1_er_cycles", 32'(n_er), 32'd0);
    for (int k = 0; k < 21; k++) check($sformatf("s1_byte%0d", k), 32'(fb[k]), 32'(exp1[k]));

    // 2: one-byte payload, padded to 60.
    start_mon(1);
    send_bytes(1, 1, 8'hAA, 1'b1);
    iv[1] = 1'b0;
    il[1] = 1'b0;
    wait_idle(1);
    analyze();
    check("s2_segments", 32'(seg_start.size()), 32'd1);
    check("s2_en_cycles", 32'(n_en), 32'd72);
    check("s2_er_cycles", 32'(n_er), 32'd0);
    check("s2_sfd", 32'(fb[7]), 32'hD5);
    check("s2_payload", 32'(fb[8]), 32'hAA);
    nz = 0;
    for (int k = 9; k < 68; k++) if (fb[k] !== 8'h00) nz++;
    check("s2_pad_nonzero", 32'(nz), 32'd0);
    check("s2_crc_residue", residue(seg_start[0], seg_len[0]), 32'hC704DD7B);

    // 3: 60-byte payload needs no padding.
    start_mon(1);
    send_bytes(1, 60, 8'h00, 1'b1);
    iv[1] = 1'b0;
    il[1] = 1'b0;
    wait_idle(1);
    analyze();
    check("s3_en_cycles", 32'(n_en), 32'd72);
    nz = 0;
    for (int k = 0; k < 60; k++) if (fb[8 + k] !== 8'(k)) nz++;
    check("s3_payload_mismatch", 32'(nz), 32'd0);
    check("s3_last_payload", 32'(fb[67]), 32'h3B);
    check("s3_crc_residue", residue(seg_start[0], seg_len[0]), 32'hC704DD7B);

    // 4: two frames back to back with in_valid held high.
    start_mon(0);
    send_bytes(0, 9, 8'h31, 1'b1);
    send_bytes(0, 9, 8'h31, 1'b1);
    iv[0] = 1'b0;
    il[0] = 1'b0;
    wait_idle(0);
    analyze();
    check("s4_segments", 32'(seg_start.size()), 32'd2);
    check("s4_len0", 32'(seg_len[0]), 32'd21);
    check("s4_len1", 32'(seg_len[1]), 32'd21);
    check("s4_gap", 32'(seg_start[1] - (seg_start[0] + seg_len[0])), 32'd13);
    check("s4_crc0", residue(seg_start[0], seg_len[0]), 32'hC704DD7B);
    check("s4_crc1", residue(seg_start[1], seg_len[1]), 32'hC704DD7B);

    // 5: underrun after 5 bytes, remainder of the frame flushed.
    start_mon(1);
    send_bytes(1, 5, 8'h10, 1'b0);
    iv[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_bytes(1, 4, 8'h20, 1'b1);
    iv[1] = 1'b0;
    il[1] = 1'b0;
    wait_idle(1);
    analyze();
    check("s5_er_cycles", 32'(n_er), 32'd1);
    check("s5_segments", 32'(seg_start.size()), 32'd1);
    check("s5_seg_len", 32'(seg_len[0]), 32'd14);
    er_idx = 0;
    for (int i = tl.size() - 1; i >= 0; i--) if (tl[i][8]) er_idx = i;
    check("s5_er_cycle_word", 32'(tl[er_idx]), 32'h300);
    nz = 0;
    for (int k = 0; k < 5; k++) if (fb[8 + k] !== 8'(8'h10 + k)) nz++;
    check("s5_payload_mismatch", 32'(nz), 32'd0);
    check("s5_in_ready_idle", 32'(ir[1]), 32'd0);

    // 6: reset during payload byte 20, then a clean frame.
    start_mon(0);
    send_bytes(0, 19, 8'h40, 1'b0);
    iv[0] = 1'b1;
    id[0] = 8'h53;
    il[0] = 1'b0;
    @(negedge clk);
    check("s6_en_before_rst", 32'(ten[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("s6_rst_tx_en", 32'(ten[0]), 32'd0);
    check("s6_rst_tx_er", 32'(ter[0]), 32'd0);
    check("s6_rst_busy", 32'(bsy[0]), 32'd0);
    check("s6_rst_in_ready", 32'(ir[0]), 32'd0);
    check("s6_rst_tx_d", 32'(td[0]), 32'd0);
    iv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    start_mon(0);
    send_bytes(0, 9, 8'h31, 1'b1);
    iv[0] = 1'b0;
    il[0] = 1'b0;
    wait_idle(0);
    analyze();
    check("s6_en_cycles", 32'(n_en), 32'd21);
    check("s6_er_cycles", 32'(n_er), 32'd0);
    for (int k = 0; k < 21; k++) check($sformatf("s6_byte%0d", k), 32'(fb[k]), 32'(exp1[k]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
